// File: rtl/cpc_rom_bus_initiator.sv
// cpc_rom_bus_initiator
//
// Bus-side initiator for the six-ROM expansion. A host request selects an
// upper ROM with an I/O write to the ROM-select port, then reads one byte with
// ROMEN* asserted and reports whether the expansion claimed the read (ROMDIS).
// The select write is skipped when the requested ROM is already the cached
// selection, unless force_sel is set with the request.
//
// Parameters
//   WAIT_CYCLES   TW clocks inserted in each bus cycle (0..15)
//   SEL_PORT      address driven during the ROM-select I/O write
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   req, force_sel      start request (taken only when idle), force select write
//   rom_num, addr       ROM number and read address, captured on acceptance
//   busy, done          transaction in progress, one-clock completion pulse
//   rd_data, no_rom     sampled read byte and "romdis was low", held until next done
//   bus_adr             CPC address bus
//   bus_data_out/_oe    write data and its drive enable
//   bus_data_in         read data from the bus
//   ioreq_b, mreq_b, rd_b, wr_b, romen_b   active-low bus strobes
//   romdis              expansion claims the ROM read
//
// state  | meaning
// IDLE   | waiting for req
// IO_T1  | select port and ROM number on the bus, strobes high
// IO_T2  | IORQ*/WR* asserted
// IO_TW  | IORQ*/WR* held for the wait clocks
// IO_T3  | strobes released, data held (expansion latches here)
// MR_T1  | read address on the bus, strobes high
// MR_T2  | MREQ*/RD* (and ROMEN* for ROM space) asserted
// MR_TW  | read strobes held for the wait clocks
// MR_T3  | strobes released, read byte captured on entry
// DONE   | done pulse, then back to IDLE
module cpc_rom_bus_initiator #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [15:0] SEL_PORT    = 16'hDF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        force_sel,
  input  logic [7:0]  rom_num,
  input  logic [15:0] addr,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rd_data,
  output logic        no_rom,
  output logic [15:0] bus_adr,
  output logic [7:0]  bus_data_out,
  output logic        bus_data_oe,
  input  logic [7:0]  bus_data_in,
  output logic        ioreq_b,
  output logic        mreq_b,
  output logic        rd_b,
  output logic        wr_b,
  output logic        romen_b,
  input  logic        romdis
);

  typedef enum logic [3:0] {
    IDLE, IO_T1, IO_T2, IO_TW, IO_T3, MR_T1, MR_T2, MR_TW, MR_T3, DONE
  } state_t;

  localparam bit         HAS_WAIT  = (WAIT_CYCLES != 0);
  // The wait counter counts down to zero, so it is loaded with one less
  // than the number of TW clocks.
  localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t      state, state_nxt;
  logic [3:0]  wait_q, wait_nxt;
  logic [7:0]  rom_q, rom_nxt;
  logic [15:0] addr_q, addr_nxt;
  logic [7:0]  cache_q;
  logic        cache_vld;

  logic [15:0] bus_adr_nxt;
  logic [7:0]  bus_data_out_nxt;
  logic        bus_data_oe_nxt;
  logic        ioreq_b_nxt, mreq_b_nxt, rd_b_nxt, wr_b_nxt, romen_b_nxt;
  logic        rom_space;

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_q;
    rom_nxt   = rom_q;
    addr_nxt  = addr_q;
    unique case (state)
      IDLE: begin
        if (req) begin
          rom_nxt  = rom_num;
          addr_nxt = addr;
          if (!cache_vld || (cache_q != rom_num) || force_sel) state_nxt = IO_T1;
          else                                                  state_nxt = MR_T1;
        end
      end
      IO_T1: state_nxt = IO_T2;
      IO_T2: begin
        if (HAS_WAIT) begin
          state_nxt = IO_TW;
          wait_nxt  = WAIT_LOAD;
        end else begin
          state_nxt = IO_T3;
        end
      end
      IO_TW: begin
        if (wait_q == 4'd0) state_nxt = IO_T3;
        else                wait_nxt  = wait_q - 4'd1;
      end
      IO_T3: state_nxt = MR_T1;
      MR_T1: state_nxt = MR_T2;
      MR_T2: begin
        if (HAS_WAIT) begin
          state_nxt = MR_TW;
          wait_nxt  = WAIT_LOAD;
        end else begin
          state_nxt = MR_T3;
        end
      end
      MR_TW: begin
        if (wait_q == 4'd0) state_nxt = MR_T3;
        else                wait_nxt  = wait_q - 4'd1;
      end
      MR_T3: state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus pins are decoded from the next state and registered, so they change
  // cleanly on the same edge as the state register.
  always_comb begin
    bus_adr_nxt      = bus_adr;
    bus_data_out_nxt = bus_data_out;
    bus_data_oe_nxt  = 1'b0;
    ioreq_b_nxt      = 1'b1;
    mreq_b_nxt       = 1'b1;
    rd_b_nxt         = 1'b1;
    wr_b_nxt         = 1'b1;
    romen_b_nxt      = 1'b1;
    rom_space        = (addr_nxt[15:14] == 2'b00) || (addr_nxt[15:14] == 2'b11);
    unique case (state_nxt)
      IO_T1, IO_T3: begin
        bus_adr_nxt      = SEL_PORT;
        bus_data_out_nxt = rom_nxt;
        bus_data_oe_nxt  = 1'b1;
      end
      IO_T2, IO_TW: begin
        bus_adr_nxt      = SEL_PORT;
        bus_data_out_nxt = rom_nxt;
        bus_data_oe_nxt  = 1'b1;
        ioreq_b_nxt      = 1'b0;
        wr_b_nxt         = 1'b0;
      end
      MR_T1, MR_T3: begin
        bus_adr_nxt = addr_nxt;
      end
      MR_T2, MR_TW: begin
        bus_adr_nxt = addr_nxt;
        mreq_b_nxt  = 1'b0;
        rd_b_nxt    = 1'b0;
        romen_b_nxt = !rom_space;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      wait_q       <= 4'd0;
      rom_q        <= 8'd0;
      addr_q       <= 16'd0;
      cache_q      <= 8'd0;
      cache_vld    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      rd_data      <= 8'd0;
      no_rom       <= 1'b0;
      bus_adr      <= 16'd0;
      bus_data_out <= 8'd0;
      bus_data_oe  <= 1'b0;
      ioreq_b      <= 1'b1;
      mreq_b       <= 1'b1;
      rd_b         <= 1'b1;
      wr_b         <= 1'b1;
      romen_b      <= 1'b1;
    end else begin
      state        <= state_nxt;
      wait_q       <= wait_nxt;
      rom_q        <= rom_nxt;
      addr_q       <= addr_nxt;
      busy         <= (state_nxt != IDLE);
      done         <= (state_nxt == DONE);
      bus_adr      <= bus_adr_nxt;
      bus_data_out <= bus_data_out_nxt;
      bus_data_oe  <= bus_data_oe_nxt;
      ioreq_b      <= ioreq_b_nxt;
      mreq_b       <= mreq_b_nxt;
      rd_b         <= rd_b_nxt;
      wr_b         <= wr_b_nxt;
      romen_b      <= romen_b_nxt;
      // The selection only becomes trustworthy once the latch edge in IO_T3
      // has been delivered; an interrupted write leaves the cache invalid.
      if (state == IO_T3) begin
        cache_q   <= rom_q;
        cache_vld <= 1'b1;
      end
      if (state_nxt == MR_T3 && state != MR_T3) begin
        rd_data <= bus_data_in;
        no_rom  <= !romdis;
      end
    end
  end

endmodule

// File: tb/tb_cpc_rom_bus_initiator.sv
// Testbench for cpc_rom_bus_initiator. Two instances run side by side on the
// same stimulus, one with one wait clock and one with none; each is checked
// against a transaction-level model (select decision, latency, strobe-low
// durations, sampled data) plus a per-clock bus monitor.
module tb_cpc_rom_bus_initiator;

  localparam logic [15:0] SEL = 16'hDF00;
  localparam int W_OF [2] = '{1, 0};

  logic        clk;
  logic        reset;
  logic        req;
  logic        force_sel;
  logic [7:0]  rom_num;
  logic [15:0] addr;
  logic [7:0]  bus_data_in;
  logic        romdis;

  logic        busy [2];
  logic        done [2];
  logic [7:0]  rd_data [2];
  logic        no_rom [2];
  logic [15:0] bus_adr [2];
  logic [7:0]  bus_data_out [2];
  logic        bus_data_oe [2];
  logic        ioreq_b [2];
  logic        mreq_b [2];
  logic        rd_b [2];
  logic        wr_b [2];
  logic        romen_b [2];

  int checks   = 0;
  int failures = 0;

  cpc_rom_bus_initiator #(.WAIT_CYCLES(1), .SEL_PORT(SEL)) u_dut_w1 (
    .clk(clk), .reset(reset), .req(req), .force_sel(force_sel),
    .rom_num(rom_num), .addr(addr), .busy(busy[0]), .done(done[0]),
    .rd_data(rd_data[0]), .no_rom(no_rom[0]), .bus_adr(bus_adr[0]),
    .bus_data_out(bus_data_out[0]), .bus_data_oe(bus_data_oe[0]),
    .bus_data_in(bus_data_in), .ioreq_b(ioreq_b[0]), .mreq_b(mreq_b[0]),
    .rd_b(rd_b[0]), .wr_b(wr_b[0]), .romen_b(romen_b[0]), .romdis(romdis)
  );

  cpc_rom_bus_initiator #(.WAIT_CYCLES(0), .SEL_PORT(SEL)) u_dut_w0 (
    .clk(clk), .reset(reset), .req(req), .force_sel(force_sel),
    .rom_num(rom_num), .addr(addr), .busy(busy[1]), .done(done[1]),
    .rd_data(rd_data[1]), .no_rom(no_rom[1]), .bus_adr(bus_adr[1]),
    .bus_data_out(bus_data_out[1]), .bus_data_oe(bus_data_oe[1]),
    .bus_data_in(bus_data_in), .ioreq_b(ioreq_b[1]), .mreq_b(mreq_b[1]),
    .rd_b(rd_b[1]), .wr_b(wr_b[1]), .romen_b(romen_b[1]), .romdis(romdis)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor: cumulative strobe-low counts and protocol violations.
  int          io_lo [2] = '{0, 0};
  int          mr_lo [2] = '{0, 0};
  int          ro_lo [2] = '{0, 0};
  int          bad   [2] = '{0, 0};
  logic [7:0]  io_dat [2];
  logic [15:0] mr_adr [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      checks++;
      assert (((!wr_b[d] && !rd_b[d]) || (!ioreq_b[d] && !mreq_b[d])) === 1'b0) else begin
        failures++;
        $error("FAIL strobe_overlap dut%0d observed ioreq_b=%b mreq_b=%b rd_b=%b wr_b=%b expected no overlap",
               d, ioreq_b[d], mreq_b[d], rd_b[d], wr_b[d]);
      end
      if (ioreq_b[d] === 1'b0) begin
        io_lo[d]++;
        io_dat[d] = bus_data_out[d];
        if (wr_b[d] !== 1'b0 || bus_adr[d] !== SEL || bus_data_oe[d] !== 1'b1 || romen_b[d] !== 1'b1)
          bad[d]++;
      end
      if (mreq_b[d] === 1'b0) begin
        mr_lo[d]++;
        mr_adr[d] = bus_adr[d];
        if (rd_b[d] !== 1'b0 || bus_data_oe[d] !== 1'b0) bad[d]++;
        if (romen_b[d] === 1'b0) ro_lo[d]++;
      end else if (romen_b[d] === 1'b0) begin
        bad[d]++;
      end
    end
  end

  // Model of the expansion-side selection as seen by both instances.
  bit         cache_v = 1'b0;
  logic [7:0] cache   = 8'h00;

  task automatic run_txn(input logic [7:0] rn, input logic [15:0] a, input logic fs,
                         input logic [7:0] din, input logic rdis, input bit extra);
    int s_io [2];
    int s_mr [2];
    int s_ro [2];
    int s_bad [2];
    int lat [2];
    bit fin [2];
    bit sel;
    bit romsp;
    int w;
    sel   = !cache_v || (cache != rn) || fs;
    romsp = (a[15:14] == 2'b00) || (a[15:14] == 2'b11);
    @(negedge clk);
    bus_data_in = din;
    romdis      = rdis;
    rom_num     = rn;
    addr        = a;
    force_sel   = fs;
    req         = 1'b1;
    for (int d = 0; d < 2; d++) begin
      s_io[d] = io_lo[d]; s_mr[d] = mr_lo[d]; s_ro[d] = ro_lo[d]; s_bad[d] = bad[d];
      fin[d] = 1'b0; lat[d] = 0;
    end
    @(negedge clk);
    req       = 1'b0;
    rom_num   = 8'($urandom);
    addr      = 16'($urandom);
    force_sel = 1'($urandom);
    for (int k = 1; k < 64; k++) begin
      for (int d = 0; d < 2; d++) begin
        if (k == 1) chk($sformatf("busy_after_accept_dut%0d", d), 64'(busy[d]), 64'd1);
        if (!fin[d] && done[d] === 1'b1) begin
          fin[d] = 1'b1;
          lat[d] = k;
        end
      end
      if (fin[0] && fin[1]) break;
      req = extra && (k == 2);
      @(negedge clk);
    end
    req = 1'b0;
    for (int d = 0; d < 2; d++) begin
      w = W_OF[d];
      chk($sformatf("done_seen_dut%0d", d), 64'(fin[d]), 64'd1);
      chk($sformatf("latency_dut%0d", d), 64'(lat[d]), sel ? 64'(7 + 2 * w) : 64'(4 + w));
      chk($sformatf("rd_data_dut%0d", d), 64'(rd_data[d]), 64'(din));
      chk($sformatf("no_rom_dut%0d", d), 64'(no_rom[d]), 64'(!rdis));
      chk($sformatf("io_low_clks_dut%0d", d), 64'(io_lo[d] - s_io[d]), sel ? 64'(1 + w) : 64'd0);
      chk($sformatf("mr_low_clks_dut%0d", d), 64'(mr_lo[d] - s_mr[d]), 64'(1 + w));
      chk($sformatf("romen_low_clks_dut%0d", d), 64'(ro_lo[d] - s_ro[d]), romsp ? 64'(1 + w) : 64'd0);
      chk($sformatf("bus_protocol_dut%0d", d), 64'(bad[d] - s_bad[d]), 64'd0);
      chk($sformatf("read_addr_dut%0d", d), 64'(mr_adr[d]), 64'(a));
      if (sel) chk($sformatf("select_data_dut%0d", d), 64'(io_dat[d]), 64'(rn));
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("idle_busy_dut%0d", d), 64'(busy[d]), 64'd0);
      chk($sformatf("idle_done_dut%0d", d), 64'(done[d]), 64'd0);
      chk($sformatf("rd_data_held_dut%0d", d), 64'(rd_data[d]), 64'(din));
    end
    if (sel) begin
      cache   = rn;
      cache_v = 1'b1;
    end
  endtask

  initial begin
    int seen;
    reset       = 1'b1;
    req         = 1'b0;
    force_sel   = 1'b0;
    rom_num     = 8'h00;
    addr        = 16'h0000;
    bus_data_in = 8'h00;
    romdis      = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      chk($sformatf("reset_values_dut%0d", d),
          64'({busy[d], done[d], rd_data[d], no_rom[d], bus_adr[d], bus_data_out[d],
               bus_data_oe[d], ioreq_b[d], mreq_b[d], rd_b[d], wr_b[d], romen_b[d]}),
          64'({1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0, 5'b11111}));

    run_txn(8'h03, 16'hC000, 1'b0, 8'hA5, 1'b1, 1'b0);
    run_txn(8'h03, 16'hC001, 1'b0, 8'($urandom), 1'b1, 1'b0);
    run_txn(8'h03, 16'hC001, 1'b1, 8'($urandom), 1'b1, 1'b0);
    run_txn(8'h03, 16'h4000, 1'b0, 8'($urandom), 1'b0, 1'b0);

    // Reset while the one-wait instance sits in IO_TW.
    @(negedge clk);
    rom_num   = 8'h05;
    addr      = 16'hC123;
    force_sel = 1'b0;
    req       = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (2) @(negedge clk);
    chk("ioreq_low_before_reset", 64'(ioreq_b[0]), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("midreset_strobes_dut%0d", d),
          64'({ioreq_b[d], mreq_b[d], rd_b[d], wr_b[d], romen_b[d]}), 64'(5'b11111));
      chk($sformatf("midreset_oe_dut%0d", d), 64'(bus_data_oe[d]), 64'd0);
      chk($sformatf("midreset_busy_dut%0d", d), 64'(busy[d]), 64'd0);
    end
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done[0] === 1'b1 || done[1] === 1'b1) seen++;
    end
    chk("no_done_after_reset", 64'(seen), 64'd0);
    cache_v = 1'b0;

    run_txn(8'h05, 16'h0123, 1'b0, 8'($urandom), 1'($urandom), 1'b0);
    run_txn(8'h05, 16'($urandom), 1'b0, 8'($urandom), 1'($urandom), 1'b1);

    for (int i = 0; i < 24; i++)
      run_txn(8'($urandom_range(0, 3)), 16'($urandom), ($urandom_range(0, 3) == 0),
              8'($urandom), 1'($urandom), 1'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
